// File: rtl/pc_sequencer.sv
// Program-counter sequencer: owns the PC, selects the next target and diverts
// misaligned control-flow targets to a trap vector through a small handler FSM.
module pc_sequencer #(
    parameter int          XLEN         = 32,
    parameter logic [31:0] RESET_VECTOR = 32'h0000_0000,
    parameter logic [31:0] TRAP_VECTOR  = 32'h0000_0100,
    parameter bit          COMPRESSED   = 1'b0,
    parameter int          CNT_W        = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             stall,
    input  logic             branch_taken,
    input  logic [XLEN-1:0]  branch_target,
    input  logic             jump,
    input  logic [XLEN-1:0]  jump_target,
    input  logic             jalr,
    input  logic [XLEN-1:0]  jalr_base,
    input  logic [XLEN-1:0]  jalr_offset,
    input  logic             trap_return,
    output logic [XLEN-1:0]  pc,
    output logic [XLEN-1:0]  pc_plus_four,
    output logic [XLEN-1:0]  epc,
    output logic             misaligned,
    output logic             in_handler,
    output logic             halted,
    output logic [CNT_W-1:0] instret
);

    typedef enum logic [1:0] {
        NORMAL  = 2'd0,
        HANDLER = 2'd1,
        HALT    = 2'd2
    } state_t;

    state_t            state_reg;
    logic [XLEN-1:0]   pc_reg;
    logic [XLEN-1:0]   epc_reg;
    logic              misaligned_reg;
    logic [CNT_W-1:0]  instret_reg;

    logic [XLEN-1:0]   jalr_sum;
    logic [XLEN-1:0]   target_next;
    logic              target_checked;
    logic              target_misaligned;
    logic              take_return;

    assign pc_plus_four = pc_reg + XLEN'(4);
    assign jalr_sum     = jalr_base + jalr_offset;
    assign take_return  = trap_return && (state_reg == HANDLER);

    // Priority mux; only branch/jump/jalr destinations are subject to the alignment check.
    always_comb begin
        target_next    = pc_plus_four;
        target_checked = 1'b0;
        if (take_return) begin
            target_next = epc_reg + XLEN'(4);
        end else if (jalr) begin
            target_next    = {jalr_sum[XLEN-1:1], 1'b0};
            target_checked = 1'b1;
        end else if (jump) begin
            target_next    = jump_target;
            target_checked = 1'b1;
        end else if (branch_taken) begin
            target_next    = branch_target;
            target_checked = 1'b1;
        end
    end

    generate
        if (COMPRESSED) begin : g_half_align
            assign target_misaligned = target_checked && target_next[0];
        end else begin : g_word_align
            assign target_misaligned = target_checked && (|target_next[1:0]);
        end
    endgenerate

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg      <= NORMAL;
            pc_reg         <= XLEN'(RESET_VECTOR);
            epc_reg        <= '0;
            misaligned_reg <= 1'b0;
            instret_reg    <= '0;
        end else begin
            misaligned_reg <= 1'b0;
            if (!stall) begin
                case (state_reg)
                    NORMAL: begin
                        instret_reg <= instret_reg + CNT_W'(1);
                        if (target_misaligned) begin
                            pc_reg         <= XLEN'(TRAP_VECTOR);
                            epc_reg        <= pc_reg;
                            misaligned_reg <= 1'b1;
                            state_reg      <= HANDLER;
                        end else begin
                            pc_reg <= target_next;
                        end
                    end
                    HANDLER: begin
                        instret_reg <= instret_reg + CNT_W'(1);
                        if (take_return) begin
                            pc_reg    <= target_next;
                            state_reg <= NORMAL;
                        end else if (target_misaligned) begin
                            // A second fault inside the handler is unrecoverable: freeze.
                            state_reg <= HALT;
                        end else begin
                            pc_reg <= target_next;
                        end
                    end
                    default: begin
                        state_reg <= HALT;
                    end
                endcase
            end
        end
    end

    assign pc         = pc_reg;
    assign epc        = epc_reg;
    assign misaligned = misaligned_reg;
    assign in_handler = (state_reg == HANDLER);
    assign halted     = (state_reg == HALT);
    assign instret    = instret_reg;

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed bench for pc_sequencer: hand-computed PC, EPC, FSM and counter values.
module tb_pc_sequencer;

    logic        clk;
    logic        rst;
    logic        stall;
    logic        branch_taken;
    logic [31:0] branch_target;
    logic        jump;
    logic [31:0] jump_target;
    logic        jalr;
    logic [31:0] jalr_base;
    logic [31:0] jalr_offset;
    logic        trap_return;
    logic [31:0] pc;
    logic [31:0] pc_plus_four;
    logic [31:0] epc;
    logic        misaligned;
    logic        in_handler;
    logic        halted;
    logic [31:0] instret;

    int errors = 0;
    int checks = 0;
    logic [31:0] exp_instret;

    pc_sequencer dut (
        .clk           (clk),
        .rst           (rst),
        .stall         (stall),
        .branch_taken  (branch_taken),
        .branch_target (branch_target),
        .jump          (jump),
        .jump_target   (jump_target),
        .jalr          (jalr),
        .jalr_base     (jalr_base),
        .jalr_offset   (jalr_offset),
        .trap_return   (trap_return),
        .pc            (pc),
        .pc_plus_four  (pc_plus_four),
        .epc           (epc),
        .misaligned    (misaligned),
        .in_handler    (in_handler),
        .halted        (halted),
        .instret       (instret)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] actual, input logic [63:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
        end else begin
            $display("ok   %s: 0x%0h", tag, actual);
        end
    endtask

    task automatic idle_inputs();
        stall = 0; branch_taken = 0; branch_target = '0; jump = 0; jump_target = '0;
        jalr = 0; jalr_base = '0; jalr_offset = '0; trap_return = 0;
    endtask

    // Advance one edge and sample 1 time unit later; cnt says whether instret should advance.
    task automatic step(input bit cnt);
        @(posedge clk);
        #1;
        if (cnt) exp_instret = exp_instret + 32'd1;
    endtask

    initial begin
        idle_inputs();
        exp_instret = 0;
        rst = 1'b1;
        #12;
        check("reset_pc", pc, 32'h0);
        check("reset_pc4", pc_plus_four, 32'h4);
        check("reset_epc", epc, 32'h0);
        check("reset_mis", misaligned, 1'b0);
        check("reset_hnd", in_handler, 1'b0);
        check("reset_hlt", halted, 1'b0);
        check("reset_instret", instret, 32'h0);
        rst = 1'b0;

        // Sequential fetch
        step(1); check("seq_pc_4", pc, 32'h4);
        step(1); check("seq_pc_8", pc, 32'h8);
        step(1); check("seq_pc_c", pc, 32'hC);
        check("seq_instret3", instret, 32'd3);
        step(1); check("seq_pc_10", pc, 32'h10);

        // Jump beats branch
        jump = 1; jump_target = 32'h40; branch_taken = 1; branch_target = 32'h80;
        step(1); idle_inputs();
        check("jump_prio_pc", pc, 32'h40);

        // JALR beats jump; bit 0 cleared before alignment check
        jalr = 1; jalr_base = 32'h101; jalr_offset = 32'h0; jump = 1; jump_target = 32'h40;
        step(1); idle_inputs();
        check("jalr_pc", pc, 32'h100);
        check("jalr_no_trap_mis", misaligned, 1'b0);
        check("jalr_no_trap_hnd", in_handler, 1'b0);

        jump = 1; jump_target = 32'h20;
        step(1); idle_inputs();
        check("jump_to_20", pc, 32'h20);

        // Misaligned branch -> trap
        branch_taken = 1; branch_target = 32'h32;
        step(1); idle_inputs();
        check("trap_pc", pc, 32'h100);
        check("trap_epc", epc, 32'h20);
        check("trap_mis", misaligned, 1'b1);
        check("trap_hnd", in_handler, 1'b1);
        check("trap_instret", instret, exp_instret);
        step(1);
        check("hnd_seq_pc", pc, 32'h104);
        check("mis_one_cycle", misaligned, 1'b0);
        check("hnd_still", in_handler, 1'b1);

        // trap_return overrides a simultaneous jump; returns to epc+4
        trap_return = 1; jump = 1; jump_target = 32'h300;
        step(1); idle_inputs();
        check("tret_pc", pc, 32'h24);
        check("tret_hnd", in_handler, 1'b0);

        // trap_return in NORMAL is ignored
        trap_return = 1;
        step(1); idle_inputs();
        check("tret_normal_pc", pc, 32'h28);

        // Misaligned JALR: 0x30+0x3 = 0x33 -> 0x32, still misaligned
        jalr = 1; jalr_base = 32'h30; jalr_offset = 32'h3;
        step(1); idle_inputs();
        check("jalr_trap_pc", pc, 32'h100);
        check("jalr_trap_epc", epc, 32'h28);
        check("jalr_trap_hnd", in_handler, 1'b1);

        // Second fault in handler -> HALT
        jump = 1; jump_target = 32'h203;
        step(1); idle_inputs();
        check("halt_flag", halted, 1'b1);
        check("halt_hnd", in_handler, 1'b0);
        check("halt_pc", pc, 32'h100);
        check("halt_epc", epc, 32'h28);
        check("halt_mis", misaligned, 1'b0);
        check("halt_instret", instret, exp_instret);
        for (int i = 0; i < 10; i++) begin
            jump = 1; jump_target = 32'h400 + 32'(i * 4); trap_return = i[0]; branch_taken = 1;
            branch_target = 32'h500;
            step(0);
            check("halt_frozen_pc", pc, 32'h100);
            check("halt_frozen_cnt", instret, exp_instret);
        end
        idle_inputs();

        // Asynchronous reset out of HALT
        #2 rst = 1'b1;
        #1;
        check("halt_rst_pc", pc, 32'h0);
        check("halt_rst_hlt", halted, 1'b0);
        check("halt_rst_cnt", instret, 32'h0);
        #1 rst = 1'b0;
        exp_instret = 0;

        step(1); step(1);
        check("pre_stall_pc", pc, 32'h8);
        stall = 1; jump = 1; jump_target = 32'h60;
        for (int i = 0; i < 4; i++) begin
            step(0);
            check("stall_pc", pc, 32'h8);
            check("stall_cnt", instret, 32'd2);
        end
        stall = 0;
        step(1); idle_inputs();
        check("post_stall_pc", pc, 32'h60);
        check("post_stall_cnt", instret, 32'd3);

        // pc_plus_four wraps
        jump = 1; jump_target = 32'hFFFF_FFFC;
        step(1); idle_inputs();
        check("wrap_pc", pc, 32'hFFFF_FFFC);
        check("wrap_pc4", pc_plus_four, 32'h0);
        step(1);
        check("wrap_next_pc", pc, 32'h0);
        check("wrap_cnt", instret, exp_instret);

        // Enter HANDLER, then reset mid-cycle
        branch_taken = 1; branch_target = 32'h62;
        step(1); idle_inputs();
        check("trap2_hnd", in_handler, 1'b1);
        check("trap2_epc", epc, 32'h0);
        jump = 1; jump_target = 32'h10;
        step(1); idle_inputs();
        check("hnd_jump_pc", pc, 32'h10);
        check("hnd_jump_hnd", in_handler, 1'b1);
        @(negedge clk);
        rst = 1'b1;
        #1;
        check("mid_rst_pc", pc, 32'h0);
        check("mid_rst_epc", epc, 32'h0);
        check("mid_rst_hnd", in_handler, 1'b0);
        check("mid_rst_cnt", instret, 32'h0);
        rst = 1'b0;
        exp_instret = 0;
        step(1);
        check("after_rst_pc", pc, 32'h4);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
